// File: rtl/sap_boot_loader_pkg.sv
// Shared definitions for the SAP boot loader: FSM state encoding,
// frame header byte and the default inter-byte timeout.
package sap_boot_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_COUNT,
        ST_DHI,
        ST_DLO,
        ST_WRITE,
        ST_CKSUM,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [7:0] HDR_BYTE        = 8'hA5;
    localparam int         DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/sap_boot_loader_if.sv
// Byte-stream input, RAM write port and CPU status bundle of the boot loader.
// The loader is the slave; the byte source / system side is the master.
interface sap_boot_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    modport slave (
        input  in_valid, in_data,
        output in_ready, ram_we, ram_addr, ram_wdata, cpu_hold, done, err
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, ram_we, ram_addr, ram_wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/sap_loader_timeout.sv
// Inter-byte watchdog: reloads to TIMEOUT on clear, counts down while enabled,
// and flags expiry during the enabled cycle that would bring it to zero.
module sap_loader_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = CW'(TIMEOUT);
        else if (en_i && cnt_q != '0)
            cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired_o = en_i && (cnt_q == CW'(1));

endmodule

// File: rtl/sap_boot_loader.sv
// Frame-driven RAM loader for the SAP core: parses A5/addr/count/words/cksum
// frames, writes words to RAM and releases the CPU only on a verified frame.
module sap_boot_loader
    import sap_boot_loader_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    sap_boot_loader_if.slave  bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        rem_q, rem_d;
    logic [7:0]        cksum_q, cksum_d;
    logic              we_q, we_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic in_ready, accept, timer_en, expired;

    assign in_ready = (state_q != ST_WRITE);
    assign accept   = bus.in_valid && in_ready;
    assign timer_en = (state_q inside {ST_ADDR, ST_COUNT, ST_DHI, ST_DLO, ST_CKSUM}) && !accept;

    sap_loader_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (!timer_en),
        .en_i      (timer_en),
        .expired_o (expired)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rem_d   = rem_q;
        cksum_d = cksum_q;
        we_d    = 1'b0;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        case (state_q)
            // A new header restarts the CPU even if the previous load succeeded.
            ST_IDLE, ST_DONE, ST_ERR: if (accept && bus.in_data == HDR_BYTE) begin
                cksum_d = '0;
                hold_d  = 1'b1;
                done_d  = 1'b0;
                err_d   = 1'b0;
                state_d = ST_ADDR;
            end
            ST_ADDR: if (accept) begin
                addr_d  = ADDR_W'(bus.in_data);
                cksum_d = cksum_q ^ bus.in_data;
                state_d = ST_COUNT;
            end
            ST_COUNT: if (accept) begin
                rem_d   = bus.in_data;
                cksum_d = cksum_q ^ bus.in_data;
                state_d = (bus.in_data == 8'd0) ? ST_CKSUM : ST_DHI;
            end
            ST_DHI: if (accept) begin
                wdata_d[DATA_W-1:DATA_W-8] = bus.in_data;
                cksum_d = cksum_q ^ bus.in_data;
                state_d = ST_DLO;
            end
            ST_DLO: if (accept) begin
                wdata_d[7:0] = bus.in_data;
                cksum_d = cksum_q ^ bus.in_data;
                we_d    = 1'b1;
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                addr_d  = addr_q + ADDR_W'(1);
                rem_d   = rem_q - 8'd1;
                state_d = (rem_q == 8'd1) ? ST_CKSUM : ST_DHI;
            end
            ST_CKSUM: if (accept) begin
                if (bus.in_data == cksum_q) begin
                    hold_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (expired) begin
            state_d = ST_ERR;
            hold_d  = 1'b1;
            done_d  = 1'b0;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rem_q   <= '0;
            cksum_q <= '0;
            we_q    <= 1'b0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rem_q   <= rem_d;
            cksum_q <= cksum_d;
            we_q    <= we_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.ram_we    = we_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.cpu_hold  = hold_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_sap_boot_loader.sv
// Self-checking bench for sap_boot_loader: directed frames from the test plan
// plus randomized frames compared against a frame-level reference model.
module tb_sap_boot_loader;

    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sap_boot_loader_if #(.ADDR_W(8), .DATA_W(16)) ifc ();

    sap_boot_loader #(.ADDR_W(8), .DATA_W(16), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int errors = 0;
    int checks = 0;
    int wideCnt = 0;
    bit prevWe = 1'b0;
    logic [23:0] wq[$];
    logic [7:0]  frameQ[$];
    logic [23:0] expQ[$];

    // Write monitor: one entry per cycle of ram_we, adjacent-cycle strobes counted as too wide.
    always @(negedge clk) begin
        if (ifc.ram_we === 1'b1) begin
            wq.push_back({ifc.ram_addr, ifc.ram_wdata});
            if (prevWe) wideCnt++;
        end
        prevWe = (ifc.ram_we === 1'b1);
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic send_byte(input logic [7:0] b);
        int guard;
        ifc.in_valid = 1'b1;
        ifc.in_data  = b;
        guard = 0;
        while (ifc.in_ready !== 1'b1 && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 8) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_byte: in_ready stuck, got %b want 1", ifc.in_ready);
        end
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    task automatic send_frame(input int gapMax);
        foreach (frameQ[i]) begin
            repeat ($urandom_range(0, gapMax)) @(negedge clk);
            send_byte(frameQ[i]);
        end
        repeat (3) @(negedge clk);
    endtask

    // Reference model: builds a frame from random words and the list of writes it must cause.
    task automatic make_frame(input logic [7:0] a, input logic [7:0] n, input bit corrupt);
        logic [7:0]  ck;
        logic [15:0] w;
        frameQ = {};
        expQ   = {};
        frameQ.push_back(8'hA5);
        frameQ.push_back(a);
        frameQ.push_back(n);
        ck = a ^ n;
        for (int k = 0; k < int'(n); k++) begin
            w = 16'($urandom);
            frameQ.push_back(w[15:8]);
            frameQ.push_back(w[7:0]);
            ck = ck ^ w[15:8] ^ w[7:0];
            expQ.push_back({8'((int'(a) + k) % 256), w});
        end
        frameQ.push_back(corrupt ? (ck ^ 8'($urandom_range(1, 255))) : ck);
    endtask

    task automatic test_reset;
        logic [28:0] got;
        got = {ifc.in_ready, ifc.ram_we, ifc.ram_addr, ifc.ram_wdata, ifc.cpu_hold, ifc.done, ifc.err};
        checks++;
        if (got !== {1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_values: got %h want %h", got, {1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0});
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        wq = {};
        frameQ = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h03};
        expQ   = '{{8'h00, 16'h0000}, {8'h01, 16'h0001}};
        send_frame(2);
        checks++;
        if (wq.size() != expQ.size()) begin
            errors++;
            $display("[TB] FAIL basic_write_count: got %0d want %0d", wq.size(), expQ.size());
        end
        foreach (expQ[k]) begin
            checks++;
            if (((k < wq.size()) ? wq[k] : 24'hxxxxxx) !== expQ[k]) begin
                errors++;
                $display("[TB] FAIL basic_write%0d: got %h want %h", k, (k < wq.size()) ? wq[k] : 24'hxxxxxx, expQ[k]);
            end
        end
        checks++;
        if ({ifc.done, ifc.err, ifc.cpu_hold} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL basic_flags: got %b want 100", {ifc.done, ifc.err, ifc.cpu_hold});
        end
    endtask

    task automatic test_wrap;
        wq = {};
        frameQ = '{8'hA5, 8'hFF, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'hF5};
        expQ   = '{{8'hFF, 16'h1234}, {8'h00, 16'h5678}};
        send_frame(0);
        checks++;
        if (wq.size() != 2) begin
            errors++;
            $display("[TB] FAIL wrap_write_count: got %0d want 2", wq.size());
        end
        foreach (expQ[k]) begin
            checks++;
            if (((k < wq.size()) ? wq[k] : 24'hxxxxxx) !== expQ[k]) begin
                errors++;
                $display("[TB] FAIL wrap_write%0d: got %h want %h", k, (k < wq.size()) ? wq[k] : 24'hxxxxxx, expQ[k]);
            end
        end
        checks++;
        if ({ifc.done, ifc.err, ifc.cpu_hold} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL wrap_flags: got %b want 100", {ifc.done, ifc.err, ifc.cpu_hold});
        end
    endtask

    task automatic test_bad_cksum;
        wq = {};
        frameQ = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h04};
        send_frame(1);
        checks++;
        if (wq.size() != 2) begin
            errors++;
            $display("[TB] FAIL badck_write_count: got %0d want 2", wq.size());
        end
        checks++;
        if ({ifc.done, ifc.err, ifc.cpu_hold} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL badck_flags: got %b want 011", {ifc.done, ifc.err, ifc.cpu_hold});
        end
        send_byte(8'hA5);
        checks++;
        if ({ifc.done, ifc.err, ifc.cpu_hold} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL badck_header_clears: got %b want 001", {ifc.done, ifc.err, ifc.cpu_hold});
        end
        frameQ = '{8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h03};
        send_frame(0);
        checks++;
        if ({ifc.done, ifc.err, ifc.cpu_hold} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL badck_reload_flags: got %b want 100", {ifc.done, ifc.err, ifc.cpu_hold});
        end
    endtask

    task automatic test_leading_garbage;
        wq = {};
        frameQ = '{8'h00, 8'h3C};
        send_frame(1);
        checks++;
        if ({ifc.done, ifc.err, ifc.cpu_hold} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL garbage_flags_held: got %b want 100", {ifc.done, ifc.err, ifc.cpu_hold});
        end
        frameQ = '{8'hA5, 8'h10, 8'h00, 8'h10};
        send_frame(1);
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("[TB] FAIL zero_count_writes: got %0d want 0", wq.size());
        end
        checks++;
        if ({ifc.done, ifc.err, ifc.cpu_hold} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL zero_count_flags: got %b want 100", {ifc.done, ifc.err, ifc.cpu_hold});
        end
    endtask

    task automatic test_timeout;
        wq = {};
        send_byte(8'hA5);
        send_byte(8'h0A);
        repeat (13) @(negedge clk);
        checks++;
        if (ifc.err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_early: got err=%b want 0", ifc.err);
        end
        repeat (4) @(negedge clk);
        checks++;
        if ({ifc.done, ifc.err, ifc.cpu_hold} !== 3'b011) begin
            errors++;
            $display("[TB] FAIL timeout_flags: got %b want 011", {ifc.done, ifc.err, ifc.cpu_hold});
        end
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("[TB] FAIL timeout_writes: got %0d want 0", wq.size());
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [28:0] got;
        frameQ = '{8'hA5, 8'h37, 8'h02};
        send_frame(0);
        wq = {};
        ifc.in_valid = 1'b1;
        ifc.in_data  = 8'h12;
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            got = {ifc.in_ready, ifc.ram_we, ifc.ram_addr, ifc.ram_wdata, ifc.cpu_hold, ifc.done, ifc.err};
            checks++;
            if (got !== {1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL midreset_values%0d: got %h want %h", c, got, {1'b1, 1'b0, 8'h00, 16'h0000, 1'b1, 1'b0, 1'b0});
            end
        end
        rst = 1'b1;
        ifc.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wq.size() != 0) begin
            errors++;
            $display("[TB] FAIL midreset_writes: got %0d want 0", wq.size());
        end
        frameQ = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h03};
        send_frame(1);
        checks++;
        if ({ifc.done, ifc.err, ifc.cpu_hold} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL midreset_reload: got %b want 100", {ifc.done, ifc.err, ifc.cpu_hold});
        end
    endtask

    task automatic test_random;
        bit corrupt;
        logic [2:0] prevFlags, wantFlags;
        for (int f = 0; f < 10; f++) begin
            prevFlags = {ifc.done, ifc.err, ifc.cpu_hold};
            frameQ = {};
            repeat ($urandom_range(0, 2)) frameQ.push_back(8'($urandom_range(0, 8'hA4)));
            send_frame(2);
            checks++;
            if ({ifc.done, ifc.err, ifc.cpu_hold} !== prevFlags) begin
                errors++;
                $display("[TB] FAIL rand%0d_garbage_hold: got %b want %b", f, {ifc.done, ifc.err, ifc.cpu_hold}, prevFlags);
            end
            corrupt = ($urandom_range(0, 3) == 0);
            wq = {};
            make_frame(8'($urandom), 8'($urandom_range(0, 5)), corrupt);
            send_frame(f % 3);
            checks++;
            if (wq.size() != expQ.size()) begin
                errors++;
                $display("[TB] FAIL rand%0d_write_count: got %0d want %0d", f, wq.size(), expQ.size());
            end
            foreach (expQ[k]) begin
                checks++;
                if (((k < wq.size()) ? wq[k] : 24'hxxxxxx) !== expQ[k]) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_write%0d: got %h want %h", f, k, (k < wq.size()) ? wq[k] : 24'hxxxxxx, expQ[k]);
                end
            end
            wantFlags = corrupt ? 3'b011 : 3'b100;
            checks++;
            if ({ifc.done, ifc.err, ifc.cpu_hold} !== wantFlags) begin
                errors++;
                $display("[TB] FAIL rand%0d_flags: got %b want %b", f, {ifc.done, ifc.err, ifc.cpu_hold}, wantFlags);
            end
        end
    endtask

    initial begin
        ifc.in_valid = 1'b0;
        ifc.in_data  = 8'h00;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_wrap();
        test_bad_cksum();
        test_leading_garbage();
        test_timeout();
        test_reset_mid_frame();
        test_random();
        checks++;
        if (wideCnt != 0) begin
            errors++;
            $display("[TB] FAIL ram_we_width: got %0d multi-cycle strobes want 0", wideCnt);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sap_boot_loader.md
Name: sap_boot_loader

Overview:
- Upstream of the 16-bit SAP core: receives a framed byte stream, writes 16-bit words into the SAP RAM write port, and holds the CPU in reset until a frame loads with a good checksum.
- Replaces hierarchical RAM preloading in simulation; the same path is used on silicon.

Parameters:
ADDR_W, 8, RAM word-address width (256 words).
DATA_W, 16, RAM word width; fixed at 2 bytes per word.
TIMEOUT, 1024, idle clock cycles allowed between bytes mid-frame before aborting.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
in_valid  input  1  byte-stream valid.
in_data  input  8  byte-stream data.
in_ready  output  1  loader accepts a byte when in_valid & in_ready at a clk edge.
ram_we  output  1  one-cycle RAM write strobe.
ram_addr  output  ADDR_W  RAM word address.
ram_wdata  output  DATA_W  RAM write data.
cpu_hold  output  1  active-high reset to the SAP core; 1 = CPU held.
done  output  1  last frame loaded and verified.
err  output  1  last frame aborted (checksum or timeout).

Behaviour:
- Interface: reset is asynchronous and active-low, named rst; single clock clk.
- Reset values: state IDLE, ram_we=0, ram_addr=0, ram_wdata=0, cpu_hold=1, done=0, err=0, checksum=0, timer=0.
- Outputs are registered, except in_ready, which is decoded from state.
- Frame format: 0xA5, start_addr, count, count×(data_hi, data_lo), cksum.
- cksum = XOR of start_addr, count and all data bytes. The header byte is excluded.
- States:
  - IDLE: in_ready=1. Discard every byte except 0xA5. On 0xA5: clear checksum, go to ADDR.
  - ADDR: latch ram_addr=byte, go to COUNT.
  - COUNT: latch remaining=byte. If 0, go to CKSUM; else go to DHI.
  - DHI: latch ram_wdata[15:8], go to DLO.
  - DLO: latch ram_wdata[7:0], go to WRITE.
  - WRITE: in_ready=0; ram_we=1 for exactly this cycle; then ram_addr+=1 (wraps 0xFF->0x00) and remaining-=1. If remaining becomes 0, go to CKSUM; else go to DHI.
  - CKSUM: if byte == checksum, go to DONE; else go to ERR.
  - DONE: cpu_hold=0, done=1, in_ready=1.
  - ERR: cpu_hold=1, err=1, in_ready=1.
- Write latency: a DLO byte accepted at edge N gives ram_we high during cycle N+1, with the ram_addr/ram_wdata of that word.
- Checksum accumulates on each accepted byte in ADDR, COUNT, DHI and DLO.
- cpu_hold and done/err:
  - cpu_hold is 1 in every state except DONE.
  - Entering ADDR clears done and err and re-asserts cpu_hold, so a reload restarts the CPU.
  - DONE and ERR behave like IDLE for byte acceptance: 0xA5 starts a new frame, other bytes are ignored and the flags are held.
- Timeout:
  - Timer counts in ADDR, COUNT, DHI, DLO and CKSUM while no byte is accepted; it resets on each accepted byte.
  - On reaching TIMEOUT, go to ERR.
  - WRITE does not count.
- Words already written before an error are not rolled back; cpu_hold staying 1 is the protection.
- Reset mid-frame: immediate return to reset values. No ram_we pulse after rst falls.
- in_valid while in_ready=0 (WRITE): the byte is not consumed. The source must hold it.

Decomposition:
- Package sap_boot_loader_pkg holds:
  - the state encoding (IDLE, ADDR, COUNT, DHI, DLO, WRITE, CKSUM, DONE, ERR);
  - HDR_BYTE=8'hA5;
  - the default TIMEOUT.
- One sub-module, sap_loader_timeout: a loadable down-counter with clear and enable inputs and an expired output, parameterised by TIMEOUT.

Test Plan:
- Frame A5 00 02 00 00 00 01 03 -> writes mem[0x00]=0x0000 and mem[0x01]=0x0001, each ram_we one cycle wide; then done=1, cpu_hold=0, err=0.
- Frame A5 FF 02 12 34 56 78 F5 -> writes mem[0xFF]=0x1234 then mem[0x00]=0x5678 (address wrap); then done=1.
- Same as scenario 1 but cksum=04 -> two writes occur; then err=1, done=0, cpu_hold stays 1. A following valid frame -> err=0, done=1.
- Bytes 00 3C then frame A5 10 00 10 -> leading bytes ignored; count=0 gives no ram_we; done=1, cpu_hold=0.
- TIMEOUT=16, send A5 0A then stall 20 cycles -> err=1 at the 16th idle cycle, cpu_hold=1, no ram_we.
- Reset during DHI of a 2-word frame, with in_valid held high on the DHI byte for 4 cycles -> all outputs at reset values, no ram_we, state IDLE. After a full valid frame: done=1.
